sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Sequences all accesses to the external 16-bit SRAM and shares it between two requesters: the SLC-3 CPU datapath (MAR/MDR traffic) and a debug/loader port (program load and memory peek from the front panel). It owns the active-low SRAM strobes, the address bus and the write-data drive enable. Each granted request becomes one fixed-length read or write cycle, and completion is signalled to the owner with a one-cycle acknowledge. It sits between the CPU and the board SRAM.

## Interface
- WAIT_CYCLES, 2, number of cycles the OE/WE strobe is held active (legal range 1–15)
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width

- Clk  in  1  system clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- cpu_req, cpu_we  in  1  CPU request; write when cpu_we=1
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to the CPU
- cpu_rdata  out  DATA_W  CPU read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port request, same meaning as the CPU fields
- dbg_ack  out  1  one-cycle completion pulse to the debug port
- dbg_rdata  out  DATA_W  debug port read data
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1  SRAM strobes, active-low
- ADDR  out  ADDR_W  SRAM address
- Data_out  out  DATA_W  write data toward the SRAM
- data_oe  out  1  enables the top-level tristate driver for Data_out
- Data_in  in  DATA_W  read data from the SRAM
- busy  out  1  high in any state other than IDLE
- owner  out  1  current or last grant: 0 = CPU, 1 = debug

## Operation
- FSM states: IDLE → SETUP → ACCESS → DONE → IDLE.
- **IDLE**
  - All strobes are high.
  - Both requests are sampled.
  - If exactly one request is high, that requester is granted.
  - If both are high, the requester that is not `owner` is granted (round robin).
  - With no request, the FSM stays in IDLE.
- **On grant**
  - `owner` is updated.
  - `we`, `addr` and `wdata` of the winner are latched into internal registers.
  - Requester inputs are ignored until DONE.
- **SETUP** (1 cycle)
  - ADDR = latched address.
  - Mem_CE = Mem_UB = Mem_LB = 0.
  - For writes, data_oe = 1 and Data_out = latched wdata.
- **ACCESS** (WAIT_CYCLES cycles, counted by an internal down-counter)
  - Mem_OE = 0 for reads, Mem_WE = 0 for writes.
  - For reads, on the last ACCESS cycle Data_in is registered into the owner's rdata register.
- **DONE** (1 cycle)
  - Mem_OE and Mem_WE return high.
  - Mem_CE, ADDR, Data_out and data_oe are held for address/data hold time.
  - The owner's ack is 1.
  - The FSM goes to IDLE next.
- **Requester rules**
  - A requester holds req and its fields stable until it sees ack.
  - A req still high in the IDLE cycle after DONE starts a new transaction.
  - Dropping req mid-transaction does not abort it; the cycle completes and ack still pulses.
- **Read data**
  - cpu_rdata and dbg_rdata are separate registers.
  - Each holds its last read value until the next read by that owner.
  - A write never modifies either register.
- Mem_OE and Mem_WE are never low in the same cycle.
- data_oe is never high while Mem_OE is low.

## Timing
- **Reset values** (applied asynchronously when Reset=0)
  - state = IDLE
  - all Mem_* = 1
  - ADDR = 0, Data_out = 0, data_oe = 0
  - both acks = 0, both rdata = 0
  - busy = 0
  - owner = 1, so the CPU wins the first contended arbitration
- Reset asserted mid-transaction:
  - Strobes go high immediately.
  - No ack is issued for the aborted access.
- Latency: request seen in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycles 2..WAIT_CYCLES+1 → ack at cycle WAIT_CYCLES+2.
- With WAIT_CYCLES=2, the ack arrives at cycle 4.
- Throughput: one access per WAIT_CYCLES+3 cycles, including the IDLE arbitration cycle.
- Back-to-back same requester: the next SETUP comes 2 cycles after the previous DONE.
- Both acks are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to Mem_* or ADDR.

## Test plan
- **Reset state:** hold Reset=0 → all strobes 1, busy=0, owner=1. Assert Reset=0 again during ACCESS → strobes high in the same cycle, no ack.
- **CPU read:** WAIT_CYCLES=2, cpu_req=1, cpu_we=0, cpu_addr=0x00123, SRAM model returns 0xBEEF → Mem_OE low for exactly 2 cycles, cpu_ack at cycle 4, cpu_rdata=0xBEEF, dbg_rdata unchanged.
- **Debug write:** dbg_req=1, dbg_we=1, addr=0x0FFFF, wdata=0x1234 → data_oe=1 from SETUP through DONE, Mem_WE low 2 cycles, Mem_OE stays 1, model memory[0x0FFFF]=0x1234, dbg_ack pulses once.
- **Contention:** cpu_req and dbg_req both held high for 4 transactions → grant order CPU, DBG, CPU, DBG, acks alternate, each transaction takes 5 cycles.
- **Early drop:** cpu_req dropped during ACCESS → transaction completes, single cpu_ack, FSM returns to IDLE and stays idle.
- **WAIT_CYCLES=1 build:** CPU read → ack at cycle 3, Mem_OE low for 1 cycle.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter and strobe sequencer for the external async SRAM.
// Each grant runs one fixed-length read or write cycle: SETUP, WAIT_CYCLES of ACCESS, then DONE with an ack.
module sram_port_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] Data_in,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;

    logic              w_any_req;
    logic              w_pick_dbg;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Contention goes to whoever did not win last time.
    assign w_any_req  = cpu_req | dbg_req;
    assign w_pick_dbg = dbg_req & (~cpu_req | ~owner);
    assign w_we       = w_pick_dbg ? dbg_we    : cpu_we;
    assign w_addr     = w_pick_dbg ? dbg_addr  : cpu_addr;
    assign w_wdata    = w_pick_dbg ? dbg_wdata : cpu_wdata;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            Mem_CE    <= 1'b1;
            Mem_UB    <= 1'b1;
            Mem_LB    <= 1'b1;
            Mem_OE    <= 1'b1;
            Mem_WE    <= 1'b1;
            ADDR      <= '0;
            Data_out  <= '0;
            data_oe   <= 1'b0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            busy      <= 1'b0;
            owner     <= 1'b1;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        owner    <= w_pick_dbg;
                        r_we     <= w_we;
                        ADDR     <= w_addr;
                        Data_out <= w_wdata;
                        data_oe  <= w_we;
                        Mem_CE   <= 1'b0;
                        Mem_UB   <= 1'b0;
                        Mem_LB   <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt   <= 4'(WAIT_CYCLES - 1);
                    Mem_OE  <= r_we;
                    Mem_WE  <= ~r_we;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        Mem_OE <= 1'b1;
                        Mem_WE <= 1'b1;
                        // Read data is captured while OE is still low.
                        if (!r_we && !owner) cpu_rdata <= Data_in;
                        if (!r_we &&  owner) dbg_rdata <= Data_in;
                        cpu_ack <= ~owner;
                        dbg_ack <= owner;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // CE, ADDR and Data_out were held through DONE for hold time.
                    Mem_CE  <= 1'b1;
                    Mem_UB  <= 1'b1;
                    Mem_LB  <= 1'b1;
                    data_oe <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: two arbiter builds (WAIT_CYCLES=2 and 1) against a small SRAM model.
module tb_sram_port_arbiter;

    logic        Clk;
    logic        Reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [19:0] cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        cpu_ack, dbg_ack, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, data_oe, busy, owner;
    logic [15:0] cpu_rdata, dbg_rdata, Data_out, Data_in;
    logic [19:0] ADDR;

    logic        c1_req;
    logic [19:0] c1_addr;
    logic        c1_ack, d1_ack, m1_CE, m1_UB, m1_LB, m1_OE, m1_WE, m1_doe, m1_busy, m1_owner;
    logic [15:0] c1_rdata, d1_rdata, m1_dout, m1_din;
    logic [19:0] m1_addr;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:4095];
    bit   [4095:0] written;

    sram_port_arbiter #(.WAIT_CYCLES(2), .ADDR_W(20), .DATA_W(16)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .ADDR(ADDR), .Data_out(Data_out), .data_oe(data_oe), .Data_in(Data_in),
        .busy(busy), .owner(owner)
    );

    sram_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20), .DATA_W(16)) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(c1_req), .cpu_we(1'b0), .cpu_addr(c1_addr), .cpu_wdata(16'h0),
        .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(20'h0), .dbg_wdata(16'h0),
        .dbg_ack(d1_ack), .dbg_rdata(d1_rdata),
        .Mem_CE(m1_CE), .Mem_UB(m1_UB), .Mem_LB(m1_LB), .Mem_OE(m1_OE), .Mem_WE(m1_WE),
        .ADDR(m1_addr), .Data_out(m1_dout), .data_oe(m1_doe), .Data_in(m1_din),
        .busy(m1_busy), .owner(m1_owner)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model: unwritten words read back a fixed pattern (0xBEEF at 0x123, else ~addr).
    function automatic logic [15:0] rom(input logic [19:0] a);
        return (a[11:0] == 12'h123) ? 16'hBEEF : ~a[15:0];
    endfunction

    assign Data_in = (!Mem_OE && !Mem_CE) ?
                     (written[ADDR[11:0]] ? mem[ADDR[11:0]] : rom(ADDR)) : 16'h0000;
    assign m1_din  = (!m1_OE && !m1_CE) ? 16'hC3C3 : 16'h0000;

    always @(posedge Clk) begin
        if (!Mem_CE && !Mem_WE && data_oe) begin
            mem[ADDR[11:0]]     <= Data_out;
            written[ADDR[11:0]] <= 1'b1;
        end
    end

    wire [4:0] strb  = {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};
    wire [4:0] strb1 = {m1_CE, m1_UB, m1_LB, m1_OE, m1_WE};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Invariants checked every cycle on the opposite edge.
    always @(negedge Clk) begin
        chk("inv_acks", {31'd0, cpu_ack & dbg_ack}, 32'd0);
        chk("inv_oe_we", {31'd0, ~Mem_OE & ~Mem_WE}, 32'd0);
        chk("inv_doe_oe", {31'd0, data_oe & ~Mem_OE}, 32'd0);
    end

    initial begin
        Reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        c1_req = 0; c1_addr = '0;
        tick(); tick();

        chk("rst_strb", strb, 5'b11111);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 1'b1);
        chk("rst_addr", ADDR, 20'h0);
        chk("rst_doe", data_oe, 1'b0);
        chk("rst_acks", {cpu_ack, dbg_ack}, 2'b00);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 32'h0);
        chk("rst1_strb", strb1, 5'b11111);
        Reset = 1'b1;
        tick();

        // CPU read of 0x00123
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00123;
        tick();
        chk("rd_c1_strb", strb, 5'b00011);
        chk("rd_c1_addr", ADDR, 20'h00123);
        chk("rd_c1_owner", owner, 1'b0);
        chk("rd_c1_busy", busy, 1'b1);
        chk("rd_c1_doe", data_oe, 1'b0);
        tick();
        chk("rd_c2_strb", strb, 5'b00001);
        tick();
        chk("rd_c3_strb", strb, 5'b00001);
        chk("rd_c3_ack", cpu_ack, 1'b0);
        tick();
        chk("rd_c4_strb", strb, 5'b00011);
        chk("rd_c4_ack", cpu_ack, 1'b1);
        chk("rd_c4_rdata", cpu_rdata, 16'hBEEF);
        chk("rd_c4_dbgrd", dbg_rdata, 16'h0);
        cpu_req = 0;
        tick();
        chk("rd_c5_strb", strb, 5'b11111);
        chk("rd_c5_ack", cpu_ack, 1'b0);
        chk("rd_c5_busy", busy, 1'b0);

        // Debug write of 0x1234 to 0x0FFFF
        dbg_req = 1; dbg_we = 1; dbg_addr = 20'h0FFFF; dbg_wdata = 16'h1234;
        tick();
        chk("wr_c1_strb", strb, 5'b00011);
        chk("wr_c1_doe", data_oe, 1'b1);
        chk("wr_c1_dout", Data_out, 16'h1234);
        chk("wr_c1_owner", owner, 1'b1);
        tick();
        chk("wr_c2_strb", strb, 5'b00010);
        chk("wr_c2_doe", data_oe, 1'b1);
        tick();
        chk("wr_c3_strb", strb, 5'b00010);
        tick();
        chk("wr_c4_strb", strb, 5'b00011);
        chk("wr_c4_acks", {cpu_ack, dbg_ack}, 2'b01);
        chk("wr_c4_doe", data_oe, 1'b1);
        dbg_req = 0; dbg_we = 0;
        tick();
        chk("wr_c5_strb", strb, 5'b11111);
        chk("wr_c5_doe", data_oe, 1'b0);
        chk("wr_c5_ack", dbg_ack, 1'b0);
        chk("wr_mem", mem[12'hFFF], 16'h1234);
        chk("wr_rdata", {cpu_rdata, dbg_rdata}, {16'hBEEF, 16'h0000});

        // Contention: both reads held for four transactions, CPU first
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 20'h00020;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("cn_owner", owner, (t % 2 == 1));
            chk("cn_busy", busy, 1'b1);
            tick(); tick(); tick();
            chk("cn_acks", {cpu_ack, dbg_ack}, (t % 2 == 0) ? 2'b10 : 2'b01);
            if (t == 3) begin
                cpu_req = 0; dbg_req = 0;
            end
            tick();
            chk("cn_idle", busy, 1'b0);
        end
        chk("cn_rdata", {cpu_rdata, dbg_rdata}, {16'hFFEF, 16'hFFDF});
        tick();
        chk("cn_stay", busy, 1'b0);

        // Early drop of cpu_req during ACCESS
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00123;
        tick(); tick();
        chk("ed_c2_strb", strb, 5'b00001);
        cpu_req = 0;
        tick(); tick();
        chk("ed_c4_ack", cpu_ack, 1'b1);
        chk("ed_c4_rdata", cpu_rdata, 16'hBEEF);
        tick();
        chk("ed_c5_ack", cpu_ack, 1'b0);
        tick();
        chk("ed_c6_busy", busy, 1'b0);
        chk("ed_c6_strb", strb, 5'b11111);
        tick();
        chk("ed_c7_busy", busy, 1'b0);

        // Reset asserted mid-ACCESS of a write
        cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00040; cpu_wdata = 16'h5555;
        tick(); tick();
        chk("ra_c2_strb", strb, 5'b00010);
        #1 Reset = 1'b0;
        #1;
        chk("ra_strb", strb, 5'b11111);
        chk("ra_busy", busy, 1'b0);
        chk("ra_doe", data_oe, 1'b0);
        chk("ra_owner", owner, 1'b1);
        cpu_req = 0; cpu_we = 0;
        tick();
        chk("ra_noack", {cpu_ack, dbg_ack}, 2'b00);
        chk("ra_nowrite", {31'd0, written[12'h040]}, 32'd0);
        chk("ra_rdata", cpu_rdata, 16'h0);
        Reset = 1'b1;
        tick();
        chk("ra_after_ack", cpu_ack, 1'b0);

        // WAIT_CYCLES=1 build: CPU read
        c1_req = 1; c1_addr = 20'h00123;
        tick();
        chk("w1_c1_strb", strb1, 5'b00011);
        tick();
        chk("w1_c2_strb", strb1, 5'b00001);
        chk("w1_c2_ack", c1_ack, 1'b0);
        tick();
        chk("w1_c3_strb", strb1, 5'b00011);
        chk("w1_c3_ack", c1_ack, 1'b1);
        chk("w1_c3_rdata", c1_rdata, 16'hC3C3);
        c1_req = 0;
        tick();
        chk("w1_c4_strb", strb1, 5'b11111);
        chk("w1_c4_ack", c1_ack, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
